// File: rtl/nrzi_pkg.sv
// Shared types and defaults for the NRZI receive framer slice.
package nrzi_pkg;
  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] SYNC_DEFAULT  = 8'hD5;
  localparam int unsigned       FRAME_DEFAULT = 16;
  localparam int unsigned       LOSS_DEFAULT  = 4;
  localparam int unsigned       RST_DEFAULT   = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESYNC,
    ST_HUNT,
    ST_DATA
  } rx_state_e;
endpackage

// File: rtl/nrzi_sync_hunt.sv
// Sliding 8-bit window over the received bit stream; flags the bit that completes SYNC_WORD.
module nrzi_sync_hunt
  import nrzi_pkg::*;
#(
  parameter logic [BYTE_W-1:0] SYNC_WORD = SYNC_DEFAULT
) (
  input  logic refclk,
  input  logic reset_n,
  input  logic clear,
  input  logic shift_en,
  input  logic bit_in,
  output logic match
);

  logic [BYTE_W-1:0] sr;
  logic [BYTE_W-1:0] sr_next;

  // Newest bit enters at the MSB so the oldest bit sits at bit 0 (LSB-first word).
  assign sr_next = {bit_in, sr[BYTE_W-1:1]};
  assign match   = shift_en && !clear && (sr_next == SYNC_WORD);

  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      sr <= '0;
    end else if (clear) begin
      sr <= '0;
    end else if (shift_en) begin
      sr <= sr_next;
    end
  end

endmodule

// File: rtl/nrzi_rx_framer.sv
// Frames NRZI decoder bits into bytes: sync hunt, fixed-length payload, loss-driven decoder resync.
module nrzi_rx_framer
  import nrzi_pkg::*;
#(
  parameter logic [BYTE_W-1:0] SYNC_WORD   = SYNC_DEFAULT,
  parameter int unsigned       FRAME_BYTES = FRAME_DEFAULT,
  parameter int unsigned       LOSS_CYCLES = LOSS_DEFAULT,
  parameter int unsigned       RST_CYCLES  = RST_DEFAULT
) (
  input  logic              refclk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              dec_oe,
  input  logic              dec_out,
  input  logic              dec_loss,
  output logic              dec_reset,
  output logic              locked,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_valid,
  output logic              byte_first,
  output logic              byte_last,
  output logic              frame_err,
  output logic [7:0]        err_cnt
);

  rx_state_e         state;
  logic              dec_oe_q;
  logic [2:0]        bit_cnt;
  logic [7:0]        byte_cnt;
  logic [3:0]        loss_cnt;
  logic [7:0]        rst_cnt;
  logic [BYTE_W-1:0] byte_sr;

  logic              bit_stb;
  logic              sync_hit;
  logic [3:0]        loss_next;
  logic              loss_trip;
  logic [BYTE_W-1:0] byte_next;
  logic              last_byte;

  assign bit_stb   = dec_oe & ~dec_oe_q;
  assign loss_next = dec_loss ? loss_cnt + 4'd1 : '0;
  assign loss_trip = ((state == ST_HUNT) || (state == ST_DATA)) && (loss_next == 4'(LOSS_CYCLES));
  assign byte_next = {dec_out, byte_sr[BYTE_W-1:1]};
  assign last_byte = (byte_cnt == 8'(FRAME_BYTES - 1));

  nrzi_sync_hunt #(
    .SYNC_WORD (SYNC_WORD)
  ) u_sync_hunt (
    .refclk   (refclk),
    .reset_n  (reset_n),
    .clear    (state != ST_HUNT),
    .shift_en ((state == ST_HUNT) && bit_stb),
    .bit_in   (dec_out),
    .match    (sync_hit)
  );

  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      dec_oe_q   <= 1'b0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      loss_cnt   <= '0;
      rst_cnt    <= '0;
      byte_sr    <= '0;
      dec_reset  <= 1'b1;
      locked     <= 1'b0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      byte_first <= 1'b0;
      byte_last  <= 1'b0;
      frame_err  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      dec_oe_q   <= dec_oe;
      byte_valid <= 1'b0;
      byte_first <= 1'b0;
      byte_last  <= 1'b0;
      frame_err  <= 1'b0;
      if (!enable) begin
        state     <= ST_IDLE;
        dec_reset <= 1'b1;
        locked    <= 1'b0;
        loss_cnt  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state     <= ST_RESYNC;
            rst_cnt   <= 8'(RST_CYCLES);
            dec_reset <= 1'b1;
            loss_cnt  <= '0;
          end
          ST_RESYNC: begin
            loss_cnt <= '0;
            if (rst_cnt <= 8'd1) begin
              state     <= ST_HUNT;
              dec_reset <= 1'b0;
            end else begin
              rst_cnt <= rst_cnt - 8'd1;
            end
          end
          ST_HUNT: begin
            loss_cnt <= loss_next;
            if (loss_trip) begin
              state     <= ST_RESYNC;
              rst_cnt   <= 8'(RST_CYCLES);
              dec_reset <= 1'b1;
              loss_cnt  <= '0;
            end else if (sync_hit) begin
              state    <= ST_DATA;
              locked   <= 1'b1;
              bit_cnt  <= '0;
              byte_cnt <= '0;
            end
          end
          ST_DATA: begin
            loss_cnt <= loss_next;
            // Loss is tested first so a coincident 8th bit never produces a byte.
            if (loss_trip) begin
              state     <= ST_RESYNC;
              rst_cnt   <= 8'(RST_CYCLES);
              dec_reset <= 1'b1;
              locked    <= 1'b0;
              loss_cnt  <= '0;
              frame_err <= 1'b1;
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end else if (bit_stb) begin
              byte_sr <= byte_next;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                byte_data  <= byte_next;
                byte_valid <= 1'b1;
                byte_first <= (byte_cnt == 8'd0);
                byte_last  <= last_byte;
                byte_cnt   <= byte_cnt + 8'd1;
                if (last_byte) begin
                  state  <= ST_HUNT;
                  locked <= 1'b0;
                end
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nrzi_rx_framer.sv
// Self-checking bench for nrzi_rx_framer: directed frame table, loss/enable/reset sequences, random streams.
module tb_nrzi_rx_framer;

  localparam logic [7:0] SYNC = 8'hD5;
  localparam int         FB   = 16;

  logic       refclk = 1'b0;
  logic       reset_n, enable, dec_oe, dec_out, dec_loss;
  logic       dec_reset, locked, byte_valid, byte_first, byte_last, frame_err;
  logic [7:0] byte_data, err_cnt;

  nrzi_rx_framer #(
    .SYNC_WORD   (8'hD5),
    .FRAME_BYTES (16),
    .LOSS_CYCLES (4),
    .RST_CYCLES  (8)
  ) dut (
    .refclk     (refclk),
    .reset_n    (reset_n),
    .enable     (enable),
    .dec_oe     (dec_oe),
    .dec_out    (dec_out),
    .dec_loss   (dec_loss),
    .dec_reset  (dec_reset),
    .locked     (locked),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_first (byte_first),
    .byte_last  (byte_last),
    .frame_err  (frame_err),
    .err_cnt    (err_cnt)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    logic [7:0] d;
    logic       first;
    logic       last;
  } byte_t;

  typedef struct {
    logic [7:0] n0;
    logic [7:0] n1;
    int         nn;
    logic [7:0] base;
    int         cnt;
    logic [7:0] first_d;
    logic [7:0] last_d;
    logic       lk;
  } vec_t;

  int    n_cmp = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    last_bit_cyc = 0;
  int    ferr_seen = 0;
  int    exp_err = 0;
  byte_t got_q[$];
  byte_t exp_q[$];
  bit    bits_q[$];

  always @(posedge refclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Byte monitor: collects delivered bytes and checks per-byte timing rules.
  always @(negedge refclk) begin
    if (byte_valid) begin
      got_q.push_back('{byte_data, byte_first, byte_last});
      chk("byte_latency", cyc, last_bit_cyc + 1);
      chk("locked_with_byte", {31'd0, locked}, {31'd0, !byte_last});
    end else begin
      chk("qual_without_valid", {30'd0, byte_first, byte_last}, 32'd0);
    end
    if (frame_err) ferr_seen++;
  end

  // Reference framing over the bit list received since the last HUNT entry.
  task automatic build_model();
    int         pos = 0;
    int         n = bits_q.size();
    int         hit;
    logic [7:0] w;
    exp_q.delete();
    while (1) begin
      hit = -1;
      for (int i = pos + 7; i < n; i++) begin
        for (int k = 0; k < 8; k++) w[k] = bits_q[i - 7 + k];
        if (w == SYNC) begin
          hit = i;
          break;
        end
      end
      if (hit < 0) return;
      pos = hit + 1;
      for (int j = 0; j < FB; j++) begin
        if (pos + 8 > n) return;
        for (int k = 0; k < 8; k++) w[k] = bits_q[pos + k];
        exp_q.push_back('{w, (j == 0), (j == FB - 1)});
        pos += 8;
      end
    end
  endtask

  task automatic compare_model();
    build_model();
    chk("model_byte_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk("model_data", got_q[i].d, exp_q[i].d);
      chk("model_first", {31'd0, got_q[i].first}, {31'd0, exp_q[i].first});
      chk("model_last", {31'd0, got_q[i].last}, {31'd0, exp_q[i].last});
    end
  endtask

  task automatic send_bit(input bit b, input bit rec);
    int hi = $urandom_range(1, 3);
    int lo = $urandom_range(1, 3);
    @(negedge refclk);
    dec_oe = 1'b1;
    dec_out = b;
    last_bit_cyc = cyc;
    if (rec) bits_q.push_back(b);
    repeat (hi - 1) @(negedge refclk);
    @(negedge refclk);
    dec_oe = 1'b0;
    repeat (lo - 1) @(negedge refclk);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int k = 0; k < 8; k++) send_bit(v[k], 1'b1);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic check_resync8();
    @(negedge refclk);
    enable = 1'b1;
    repeat (8) begin
      @(negedge refclk);
      chk("resync_hold", {31'd0, dec_reset}, 32'd1);
    end
    @(negedge refclk);
    chk("resync_release", {31'd0, dec_reset}, 32'd0);
    bits_q.delete();
    got_q.delete();
  endtask

  task automatic restart();
    @(negedge refclk);
    enable = 1'b0;
    @(negedge refclk);
    chk("idle_dec_reset", {31'd0, dec_reset}, 32'd1);
    chk("idle_locked", {31'd0, locked}, 32'd0);
    check_resync8();
  endtask

  task automatic wait_hunt();
    int n = 0;
    while (dec_reset && n < 40) begin
      @(negedge refclk);
      n++;
    end
    chk("hunt_timeout", {31'd0, dec_reset}, 32'd0);
    bits_q.delete();
    got_q.delete();
  endtask

  task automatic loss_abort();
    @(negedge refclk);
    dec_loss = 1'b1;
    repeat (3) @(negedge refclk);
    @(negedge refclk);
    dec_loss = 1'b0;
    chk("abort_frame_err", {31'd0, frame_err}, 32'd1);
    chk("abort_dec_reset", {31'd0, dec_reset}, 32'd1);
    chk("abort_locked", {31'd0, locked}, 32'd0);
    exp_err = (exp_err >= 255) ? 255 : exp_err + 1;
    chk("abort_err_cnt", err_cnt, exp_err);
    repeat (7) begin
      @(negedge refclk);
      chk("abort_resync_hold", {31'd0, dec_reset}, 32'd1);
      chk("abort_err_pulse", {31'd0, frame_err}, 32'd0);
    end
    @(negedge refclk);
    chk("abort_resync_release", {31'd0, dec_reset}, 32'd0);
    bits_q.delete();
    got_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   fe0;
    // 0x93,0x6C noise is sync-free; 0xAB,0x6A hides D5 across its byte boundary.
    vecs[0] = '{8'h00, 8'h00, 0, 8'h00, 16, 8'h00, 8'h0F, 1'b0};
    vecs[1] = '{8'h93, 8'h6C, 2, 8'h10, 16, 8'h10, 8'h1F, 1'b0};
    vecs[2] = '{8'hAB, 8'h6A, 2, 8'h00, 16, 8'hAA, 8'h1C, 1'b1};
    vecs[3] = '{8'hD5, 8'h00, 1, 8'h40, 16, 8'hD5, 8'h4E, 1'b1};

    reset_n = 1'b0; enable = 1'b0; dec_oe = 1'b0; dec_out = 1'b0; dec_loss = 1'b0;
    tick(3);
    chk("rst_dec_reset", {31'd0, dec_reset}, 32'd1);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_byte_data", byte_data, 32'd0);
    chk("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_err_cnt", err_cnt, 32'd0);
    reset_n = 1'b1;
    tick(3);
    chk("idle_hold", {31'd0, dec_reset}, 32'd1);
    check_resync8();

    for (int v = 0; v < 4; v++) begin
      restart();
      if (vecs[v].nn >= 1) send_byte(vecs[v].n0);
      if (vecs[v].nn >= 2) send_byte(vecs[v].n1);
      chk("lock_after_noise", {31'd0, locked}, {31'd0, vecs[v].lk});
      send_byte(SYNC);
      for (int i = 0; i < FB; i++) send_byte(vecs[v].base + 8'(i));
      tick(3);
      chk("row_count", got_q.size(), vecs[v].cnt);
      if (got_q.size() > 0) begin
        chk("row_first_data", got_q[0].d, vecs[v].first_d);
        chk("row_last_data", got_q[got_q.size() - 1].d, vecs[v].last_d);
      end
      chk("row_unlocked_after", {31'd0, locked}, 32'd0);
      compare_model();
    end

    for (int r = 0; r < 6; r++) begin
      restart();
      repeat ($urandom_range(0, 24)) send_bit(1'($urandom_range(0, 1)), 1'b1);
      send_byte(SYNC);
      for (int i = 0; i < FB; i++) send_byte(8'($urandom_range(0, 255)));
      tick(3);
      compare_model();
    end

    restart();
    send_byte(SYNC);
    for (int i = 0; i < 3; i++) send_byte(8'hA0 + 8'(i));
    tick(2);
    fe0 = ferr_seen;
    @(negedge refclk);
    dec_loss = 1'b1;
    repeat (2) @(negedge refclk);
    @(negedge refclk);
    dec_loss = 1'b0;
    tick(2);
    chk("short_loss_locked", {31'd0, locked}, 32'd1);
    chk("short_loss_no_err", ferr_seen, fe0);
    send_byte(8'hA3);
    tick(2);
    compare_model();
    chk("pre_abort_bytes", got_q.size(), 32'd4);
    loss_abort();
    tick(2);
    chk("abort_pulse_count", ferr_seen, fe0 + 1);

    send_byte(SYNC);
    for (int i = 0; i < 4; i++) send_byte(8'hB0 + 8'(i));
    for (int k = 0; k < 7; k++) send_bit(1'(8'hB4 >> k), 1'b1);
    @(negedge refclk);
    dec_loss = 1'b1;
    repeat (2) @(negedge refclk);
    @(negedge refclk);
    dec_oe = 1'b1;
    dec_out = 1'b1;
    last_bit_cyc = cyc;
    @(negedge refclk);
    dec_oe = 1'b0;
    dec_loss = 1'b0;
    chk("coincide_frame_err", {31'd0, frame_err}, 32'd1);
    chk("coincide_no_byte", {31'd0, byte_valid}, 32'd0);
    exp_err = exp_err + 1;
    chk("coincide_err_cnt", err_cnt, exp_err);
    compare_model();
    wait_hunt();

    for (int a = 0; a < 256; a++) begin
      send_byte(SYNC);
      loss_abort();
    end
    chk("err_cnt_saturated", err_cnt, 32'd255);

    send_byte(SYNC);
    send_byte(8'h11);
    send_byte(8'h22);
    for (int k = 0; k < 3; k++) send_bit(1'b1, 1'b1);
    fe0 = ferr_seen;
    @(negedge refclk);
    enable = 1'b0;
    @(negedge refclk);
    chk("disable_dec_reset", {31'd0, dec_reset}, 32'd1);
    chk("disable_locked", {31'd0, locked}, 32'd0);
    chk("disable_no_err", {31'd0, frame_err}, 32'd0);
    tick(2);
    chk("disable_err_cnt", err_cnt, 32'd255);
    chk("disable_no_pulse", ferr_seen, fe0);

    check_resync8();
    send_byte(SYNC);
    send_byte(8'h5A);
    send_byte(8'hC3);
    chk("mid_data_locked", {31'd0, locked}, 32'd1);
    chk("mid_data_byte", byte_data, 32'hC3);
    #2;
    reset_n = 1'b0;
    enable = 1'b0;
    #1;
    chk("async_dec_reset", {31'd0, dec_reset}, 32'd1);
    chk("async_locked", {31'd0, locked}, 32'd0);
    chk("async_byte_data", byte_data, 32'd0);
    chk("async_err_cnt", err_cnt, 32'd0);
    chk("async_flags", {28'd0, byte_valid, byte_first, byte_last, frame_err}, 32'd0);
    @(negedge refclk);
    reset_n = 1'b1;
    tick(2);
    check_resync8();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
